// File: rtl/weight_update_pkg.sv
// Shared constants for the weight-update block: data format, slot map and FSM encoding.
package weight_update_pkg;

    localparam int WIDTH  = 16;
    localparam int NPARAM = 17;
    localparam int IDX_W  = 5;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPARAM - 1);

    localparam int IDX_W3_11 = 0;
    localparam int IDX_W3_21 = 1;
    localparam int IDX_W3_31 = 2;
    localparam int IDX_W3_12 = 3;
    localparam int IDX_W3_22 = 4;
    localparam int IDX_W3_32 = 5;
    localparam int IDX_W2_11 = 6;
    localparam int IDX_W2_21 = 7;
    localparam int IDX_W2_12 = 8;
    localparam int IDX_W2_22 = 9;
    localparam int IDX_W2_13 = 10;
    localparam int IDX_W2_23 = 11;
    localparam int IDX_B3_1  = 12;
    localparam int IDX_B3_2  = 13;
    localparam int IDX_B2_1  = 14;
    localparam int IDX_B2_2  = 15;
    localparam int IDX_B2_3  = 16;

    localparam logic [WIDTH-1:0] ONE = 16'h0400;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/wu_sat_sub.sv
// One-slot gradient step: new_w = w - (cap >>> LR_SHIFT).
// Build option WU_SAT_EN clamps the result to the Q6.10 range; otherwise it wraps.
module wu_sat_sub
    import weight_update_pkg::*;
#(
    parameter int LR_SHIFT = 4
)(
    input  logic [WIDTH-1:0] i_w,
    input  logic [WIDTH-1:0] i_cap,
    output logic [WIDTH-1:0] o_w
);

    logic signed [WIDTH-1:0] w_step;

    // Arithmetic shift floors toward minus infinity, so small negative gradients still move w.
    assign w_step = $signed(i_cap) >>> LR_SHIFT;

`ifdef WU_SAT_EN
    logic signed [WIDTH:0] w_diff;

    assign w_diff = {i_w[WIDTH-1], i_w} - {w_step[WIDTH-1], w_step};

    // NOTE: o_w gets a default before the conditional override so no latch is inferred.
    always_comb begin
        o_w = w_diff[WIDTH-1:0];
        if (w_diff[WIDTH] != w_diff[WIDTH-1]) begin
            o_w = w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign o_w = i_w - w_step;
`endif

endmodule

// File: rtl/weight_update.sv
// Live weight/bias store: captures a gradient set via valid/ready and applies it one slot per cycle.
// Saturating arithmetic is selected with the WU_SAT_EN macro (see wu_sat_sub).
module weight_update
    import weight_update_pkg::*;
#(
    parameter int LR_SHIFT = 4
)(
    input  logic                    clk,
    input  logic                    res,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [NPARAM*WIDTH-1:0] cap_bus,
    input  logic                    init_we,
    input  logic [IDX_W-1:0]        init_addr,
    input  logic [WIDTH-1:0]        init_data,
    output logic [NPARAM*WIDTH-1:0] w_bus,
    output logic                    w_stable,
    output logic                    upd_done
);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_shadow [NPARAM];
    logic [WIDTH-1:0] r_w      [NPARAM];
    logic             w_accept;
    logic             w_init_ok;
    logic [WIDTH-1:0] w_new;

    assign upd_ready = (r_state == ST_IDLE) && !init_we;
    assign w_stable  = (r_state == ST_IDLE);
    assign upd_done  = (r_state == ST_DONE);
    assign w_accept  = upd_valid && upd_ready;
    assign w_init_ok = init_we && (r_state == ST_IDLE) && (init_addr <= IDX_LAST);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_UPDATE;
            ST_UPDATE: if (r_idx == IDX_LAST) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_idx <= '0;
            end else if ((r_state == ST_UPDATE) && (r_idx != IDX_LAST)) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // NOTE: the shadow copy is always loaded before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < NPARAM; i++) begin
                r_shadow[i] <= cap_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    wu_sat_sub #(
        .LR_SHIFT (LR_SHIFT)
    ) u_sat (
        .i_w   (r_w[r_idx]),
        .i_cap (r_shadow[r_idx]),
        .o_w   (w_new)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < NPARAM; i++) begin
                r_w[i] <= '0;
            end
        end else if (w_init_ok) begin
            r_w[init_addr] <= init_data;
        end else if (r_state == ST_UPDATE) begin
            r_w[r_idx] <= w_new;
        end
    end

    always_comb begin
        for (int i = 0; i < NPARAM; i++) begin
            w_bus[i*WIDTH +: WIDTH] = r_w[i];
        end
    end

endmodule

// File: tb/tb_weight_update.sv
// Directed bench for weight_update with a scoreboard of expected weight sets (LR_SHIFT = 4).
module tb_weight_update;
    import weight_update_pkg::*;

    localparam int NB = NPARAM * WIDTH;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [NB-1:0] cap_bus = '0;
    logic          init_we = 1'b0;
    logic [4:0]    init_addr = '0;
    logic [15:0]   init_data = '0;
    logic [NB-1:0] w_bus;
    logic          w_stable;
    logic          upd_done;

    logic [15:0]   m_w [NPARAM];
    logic [NB-1:0] exp_q [$];
    logic [NB-1:0] cap_v;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc;

    weight_update #(.LR_SHIFT(4)) dut (
        .clk       (clk),
        .res       (res),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .cap_bus   (cap_bus),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .w_bus     (w_bus),
        .w_stable  (w_stable),
        .upd_done  (upd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_upd(input logic [15:0] w, input logic [15:0] cap);
        int step;
        int diff;
        step = int'($signed(cap)) >>> 4;
        diff = int'($signed(w)) - step;
`ifdef WU_SAT_EN
        if (diff > 32767)  return 16'h7FFF;
        if (diff < -32768) return 16'h8000;
`endif
        return diff[15:0];
    endfunction

    function automatic logic [NB-1:0] model_bus();
        logic [NB-1:0] b;
        for (int i = 0; i < NPARAM; i++) b[i*WIDTH +: WIDTH] = m_w[i];
        return b;
    endfunction

    function automatic logic [15:0] slot(input logic [NB-1:0] b, input int i);
        return b[i*WIDTH +: WIDTH];
    endfunction

    task automatic apply_model(input logic [NB-1:0] cap);
        for (int i = 0; i < NPARAM; i++) m_w[i] = model_upd(m_w[i], cap[i*WIDTH +: WIDTH]);
    endtask

    task automatic init_write(input logic [4:0] addr, input logic [15:0] data);
        init_we   = 1'b1;
        init_addr = addr;
        init_data = data;
        if (addr < 5'(NPARAM)) m_w[addr] = data;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    // Counts negedges from a given start until upd_done shows; bounded at 40.
    task automatic wait_done(input int start, output int n);
        n = start;
        do begin
            @(negedge clk);
            n++;
        end while (!upd_done && n < 40);
    endtask

    initial begin
        for (int i = 0; i < NPARAM; i++) m_w[i] = '0;

        // Reset and idle state.
        repeat (2) @(negedge clk);
        check("in_reset_wbus", w_bus, '0);
        res = 1'b1;
        @(negedge clk);
        check("idle_wbus", w_bus, '0);
        check("idle_ready", NB'(upd_ready), NB'(1));
        check("idle_stable", NB'(w_stable), NB'(1));
        check("idle_done", NB'(upd_done), NB'(0));

        // Init write and handshake requested together: init wins.
        cap_bus   = {NPARAM{16'h0100}};
        upd_valid = 1'b1;
        init_we   = 1'b1;
        init_addr = 5'd0;
        init_data = ONE;
        m_w[0]    = ONE;
        #1;
        check("init_blocks_ready", NB'(upd_ready), NB'(0));
        @(negedge clk);
        init_we   = 1'b0;
        upd_valid = 1'b0;
        check("init_vs_valid_stable", NB'(w_stable), NB'(1));
        check("init_slot0", NB'(slot(w_bus, 0)), NB'(16'h0400));

        // Out-of-range init addresses are dropped.
        init_write(5'd17, 16'h1234);
        init_write(5'd31, 16'h4321);
        init_write(5'd13, ONE);
        init_write(5'd5, 16'h7FF0);
        check("init_bus", w_bus, model_bus());

        // First update: latency, cap_bus sampled only at handshake, init ignored mid-update.
        cap_v = '0;
        cap_v[0*WIDTH +: WIDTH]  = 16'h0100;
        cap_v[5*WIDTH +: WIDTH]  = 16'h8000;
        cap_v[7*WIDTH +: WIDTH]  = 16'h0123;
        cap_v[13*WIDTH +: WIDTH] = 16'hFF00;
        cap_bus   = cap_v;
        upd_valid = 1'b1;
        #1;
        check("upd1_ready", NB'(upd_ready), NB'(1));
        apply_model(cap_v);
        exp_q.push_back(model_bus());
        @(negedge clk);
        upd_valid = 1'b0;
        cap_bus   = '1;
        check("upd1_slot0_before", NB'(slot(w_bus, 0)), NB'(16'h0400));
        check("upd1_busy_stable", NB'(w_stable), NB'(0));
        @(negedge clk);
        check("upd1_slot0_edge1", NB'(slot(w_bus, 0)), NB'(16'h03F0));
        check("upd1_busy_ready", NB'(upd_ready), NB'(0));
        init_we   = 1'b1;
        init_addr = 5'd1;
        init_data = 16'h5555;
        @(negedge clk);
        init_we = 1'b0;
        wait_done(2, cyc);
        check("upd1_done_latency", NB'(cyc), NB'(17));
        check("upd1_done_ready", NB'(upd_ready), NB'(0));
        check("upd1_result", w_bus, exp_q.pop_front());
        check("upd1_slot13", NB'(slot(w_bus, 13)), NB'(16'h0410));
`ifdef WU_SAT_EN
        check("upd1_slot5_sat", NB'(slot(w_bus, 5)), NB'(16'h7FFF));
`else
        check("upd1_slot5_wrap", NB'(slot(w_bus, 5)), NB'(16'h87F0));
`endif
        @(negedge clk);
        check("upd1_done_pulse", NB'(upd_done), NB'(0));
        check("upd1_ready_again", NB'(upd_ready), NB'(1));

        // Back-to-back sets with upd_valid held high.
        cap_v = '0;
        cap_v[0*WIDTH +: WIDTH]  = 16'h0040;
        cap_v[9*WIDTH +: WIDTH]  = 16'hFFF0;
        cap_v[16*WIDTH +: WIDTH] = 16'h0FFF;
        cap_bus   = cap_v;
        upd_valid = 1'b1;
        apply_model(cap_v);
        exp_q.push_back(model_bus());
        apply_model(cap_v);
        exp_q.push_back(model_bus());
        @(negedge clk);
        wait_done(0, cyc);
        check("b2b_first_latency", NB'(cyc), NB'(17));
        check("b2b_first_result", w_bus, exp_q.pop_front());
        wait_done(0, cyc);
        upd_valid = 1'b0;
        check("b2b_period", NB'(cyc), NB'(19));
        check("b2b_second_result", w_bus, exp_q.pop_front());
        repeat (2) @(negedge clk);
        check("b2b_no_third", NB'(w_stable), NB'(1));

        // Reset while idx = 8.
        cap_bus   = {NPARAM{16'h0100}};
        upd_valid = 1'b1;
        apply_model(cap_bus);
        exp_q.push_back(model_bus());
        @(negedge clk);
        upd_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mid_busy", NB'(w_stable), NB'(0));
        res = 1'b0;
        for (int i = 0; i < NPARAM; i++) m_w[i] = '0;
        exp_q.delete();
        #1;
        check("rst_mid_wbus", w_bus, model_bus());
        check("rst_mid_stable", NB'(w_stable), NB'(1));
        @(negedge clk);
        check("rst_mid_no_done", NB'(upd_done), NB'(0));
        res = 1'b1;
        @(negedge clk);
        check("rst_release_ready", NB'(upd_ready), NB'(1));
        check("rst_release_done", NB'(upd_done), NB'(0));
        check("rst_release_wbus", w_bus, '0);

        // Negative overflow on the last slot.
        init_write(5'd16, 16'h8010);
        cap_v = '0;
        cap_v[16*WIDTH +: WIDTH] = 16'h7FF0;
        cap_bus   = cap_v;
        upd_valid = 1'b1;
        apply_model(cap_v);
        exp_q.push_back(model_bus());
        @(negedge clk);
        upd_valid = 1'b0;
        wait_done(0, cyc);
        check("neg_latency", NB'(cyc), NB'(17));
        check("neg_result", w_bus, exp_q.pop_front());
`ifdef WU_SAT_EN
        check("neg_slot16_sat", NB'(slot(w_bus, 16)), NB'(16'h8000));
`else
        check("neg_slot16_wrap", NB'(slot(w_bus, 16)), NB'(16'h7811));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
